fns_cac_encoder_seq: RTL and testbench

Parametrised, multi-cycle Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder. Converts a DATA_W-bit binary word into a CODE_W-bit FNS codeword by greedy Fibonacci decomposition, resolving STEPS digits per clock. It replaces the fixed 11-to-16-bit single-shot encoder on bus-driver paths that need wider buses or reduced combinational depth, and adds valid/ready flow control on both sides.

---
 rtl/fns_cac_pkg.sv | 35 +++
 rtl/fns_cac_encoder_seq_stage.sv | 15 +
 rtl/fns_cac_encoder_seq.sv | 132 +++++++++++++
 tb/tb_fns_cac_encoder_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fns_cac_pkg.sv
// Shared types and constant helpers for the Fibonacci-numeral-system CAC encoder.
package fns_cac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fns_state_e;

    // Fibonacci weight of digit k (1-based): 1, 1, 2, 3, 5, ...
    function automatic logic [63:0] fns_weight(input int k);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        a = 64'd1;
        b = 64'd1;
        if (k < 1) return 64'd0;
        for (int i = 3; i <= k; i++) begin
            c = a + b;
            a = b;
            b = c;
        end
        return b;
    endfunction

    function automatic logic [63:0] fns_weight_sum(input int n);
        logic [63:0] s;
        s = 64'd0;
        for (int i = 1; i <= n; i++) s = s + fns_weight(i);
        return s;
    endfunction

    function automatic int fns_rem_w(input int data_w, input int code_w);
        int w;
        w = $clog2(fns_weight_sum(code_w) + 64'd1);
        return (w > data_w) ? w : data_w;
    endfunction

endpackage

// File: rtl/fns_cac_encoder_seq_stage.sv
// One greedy Fibonacci digit: emit the digit and subtract its weight when it fits.
module fns_digit_stage #(
    parameter int REM_W = 12
) (
    input  logic             active,
    input  logic [REM_W-1:0] rem_in,
    input  logic [REM_W-1:0] weight,
    output logic             digit,
    output logic [REM_W-1:0] rem_out
);

    assign digit   = active && (rem_in >= weight);
    assign rem_out = digit ? (rem_in - weight) : rem_in;

endmodule

// File: rtl/fns_cac_encoder_seq.sv
// Multi-cycle FNS crosstalk-avoidance encoder, STEPS greedy digits per clock.
// Optional range flag on out-of-coverage inputs when CAC_RANGE_CHECK_EN is defined.
module fns_cac_encoder_seq
    import fns_cac_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int CODE_W = 16,
    parameter int STEPS  = 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] datain,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] codeout
`ifdef CAC_RANGE_CHECK_EN
    ,
    output logic              range_err
`endif
);

    localparam int REM_W = fns_rem_w(DATA_W, CODE_W);
    localparam int KW    = $clog2(CODE_W + 1);
    localparam int NTAB  = 2 ** KW;

    fns_state_e        state_q, state_d;
    logic [REM_W-1:0]  rem_q;
    logic [KW-1:0]     k_q;
    logic [CODE_W-1:0] code_q;
    logic              last;

    // Constant weight lookup indexed by the live digit position; unused slots are zero.
    logic [REM_W-1:0]  weight_tab [NTAB];
    for (genvar j = 0; j < NTAB; j++) begin : g_wtab
        if (j >= 1 && j <= CODE_W) begin : g_w
            assign weight_tab[j] = REM_W'(fns_weight(j));
        end else begin : g_z
            assign weight_tab[j] = '0;
        end
    end

    logic [REM_W-1:0]  rem_chain  [STEPS+1];
    logic [CODE_W-1:0] code_chain [STEPS+1];
    assign rem_chain[0]  = rem_q;
    assign code_chain[0] = code_q;

    for (genvar s = 0; s < STEPS; s++) begin : g_stage
        logic          active;
        logic          digit;
        logic [KW-1:0] idx;

        assign active = (k_q > KW'(s));
        assign idx    = k_q - KW'(s);

        fns_digit_stage #(.REM_W(REM_W)) u_stage (
            .active  (active),
            .rem_in  (rem_chain[s]),
            .weight  (weight_tab[idx]),
            .digit   (digit),
            .rem_out (rem_chain[s+1])
        );

        assign code_chain[s+1] = code_chain[s] |
                                 (digit ? (CODE_W'(1) << (idx - KW'(1))) : '0);
    end

    assign last = (k_q <= KW'(STEPS));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // codeout is loaded only when the final digit resolves, so partial codes stay hidden.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            k_q     <= '0;
            code_q  <= '0;
            codeout <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rem_q  <= REM_W'(datain);
                        code_q <= '0;
                        k_q    <= KW'(CODE_W);
                    end
                end
                RUN: begin
                    rem_q  <= rem_chain[STEPS];
                    code_q <= code_chain[STEPS];
                    k_q    <= k_q - KW'(STEPS);
                    if (last) codeout <= code_chain[STEPS];
                end
                default: ;
            endcase
        end
    end

`ifdef CAC_RANGE_CHECK_EN
    localparam logic [63:0] WSUM = fns_weight_sum(CODE_W);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                          range_err <= 1'b0;
        else if (state_q == IDLE && in_valid) range_err <= (64'(datain) > WSUM);
    end
`endif

endmodule

// File: tb/tb_fns_cac_encoder_seq.sv
// Self-checking bench: three encoders (STEPS = 1, 4, 16) against a greedy Fibonacci model.
module tb_fns_cac_encoder_seq;

    localparam int ND = 3;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [10:0] datain = '0;
    logic        in_ready  [ND];
    logic        out_valid [ND];
    logic [15:0] codeout   [ND];
`ifdef CAC_RANGE_CHECK_EN
    logic        range_err [ND];
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    fns_cac_encoder_seq #(.DATA_W(11), .CODE_W(16), .STEPS(1)) u_s1 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .datain(datain), .out_valid(out_valid[0]), .out_ready(out_ready), .codeout(codeout[0])
`ifdef CAC_RANGE_CHECK_EN
        , .range_err(range_err[0])
`endif
    );

    fns_cac_encoder_seq #(.DATA_W(11), .CODE_W(16), .STEPS(4)) u_s4 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .datain(datain), .out_valid(out_valid[1]), .out_ready(out_ready), .codeout(codeout[1])
`ifdef CAC_RANGE_CHECK_EN
        , .range_err(range_err[1])
`endif
    );

    fns_cac_encoder_seq #(.DATA_W(11), .CODE_W(16), .STEPS(16)) u_s16 (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .datain(datain), .out_valid(out_valid[2]), .out_ready(out_ready), .codeout(codeout[2])
`ifdef CAC_RANGE_CHECK_EN
        , .range_err(range_err[2])
`endif
    );

    function automatic int r_lat(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int fib(input int k);
        int a, b, t;
        a = 1;
        b = 1;
        for (int i = 3; i <= k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    function automatic logic [15:0] ref_encode(input int data);
        int          rem;
        logic [15:0] c;
        rem = data;
        c   = '0;
        for (int k = 16; k >= 1; k--) begin
            if (rem >= fib(k)) begin
                c[k-1] = 1'b1;
                rem    = rem - fib(k);
            end
        end
        return c;
    endfunction

    function automatic int weighted_sum(input logic [15:0] c);
        int s;
        s = 0;
        for (int k = 1; k <= 16; k++) if (c[k-1]) s = s + fib(k);
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Transaction-level model: per encoder, busy flag, edges since accept, pending and visible code.
    bit          m_busy [ND];
    int          m_cnt  [ND];
    logic [15:0] m_code [ND];
    logic [15:0] m_out  [ND];
    logic        m_err  [ND];

    initial begin
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 0; m_cnt[d] = 0; m_code[d] = '0; m_out[d] = '0; m_err[d] = 1'b0;
        end
    end

    always @(posedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                m_busy[d] = 0; m_cnt[d] = 0; m_out[d] = '0; m_err[d] = 1'b0;
            end else if (m_busy[d]) begin
                if (m_cnt[d] >= r_lat(d)) begin
                    if (out_ready) m_busy[d] = 0;
                end else begin
                    m_cnt[d]++;
                    if (m_cnt[d] == r_lat(d)) m_out[d] = m_code[d];
                end
            end else if (in_valid) begin
                m_busy[d] = 1;
                m_cnt[d]  = 0;
                m_code[d] = ref_encode(int'(datain));
                m_err[d]  = (int'(datain) > 2583);
            end
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                checkOutput($sformatf("s%0d reset out_valid", d), out_valid[d], 1'b0);
                checkOutput($sformatf("s%0d reset in_ready", d), in_ready[d], 1'b1);
                checkOutput($sformatf("s%0d reset codeout", d), codeout[d], 16'h0000);
            end else begin
                checkOutput($sformatf("s%0d out_valid", d), out_valid[d],
                            (m_busy[d] && m_cnt[d] >= r_lat(d)));
                checkOutput($sformatf("s%0d in_ready", d), in_ready[d], !m_busy[d]);
                checkOutput($sformatf("s%0d codeout", d), codeout[d], m_out[d]);
`ifdef CAC_RANGE_CHECK_EN
                checkOutput($sformatf("s%0d range_err", d), range_err[d], m_err[d]);
`endif
            end
        end
    end

    task automatic waitAllIdle();
        int n;
        n = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle wait: in_ready still low after %0d cycles, required 1", n);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] data, input logic [15:0] exp_code);
        int          lat [ND];
        logic [15:0] got [ND];
        waitAllIdle();
        @(posedge clock); #2;
        datain   = data;
        in_valid = 1'b1;
        @(posedge clock); #2;
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++) begin lat[d] = -1; got[d] = '0; end
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) begin @(posedge clock); #1; end
            else       begin #(8); #1; end
            for (int d = 0; d < ND; d++)
                if (lat[d] < 0 && out_valid[d]) begin lat[d] = n; got[d] = codeout[d]; end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        checkOutput($sformatf("model pin %0d", data), ref_encode(int'(data)), exp_code);
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("s%0d latency for %0d", d, data), 64'(lat[d]), 64'(r_lat(d)));
            checkOutput($sformatf("s%0d code for %0d", d, data), got[d], exp_code);
        end
        checkOutput($sformatf("weighted sum for %0d", data), 64'(weighted_sum(got[0])), 64'(data));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clock); #1;
        checkOutput("initial out_valid", out_valid[0], 1'b0);
        checkOutput("initial in_ready", in_ready[0], 1'b1);
        checkOutput("initial codeout", codeout[0], 16'h0000);
        @(posedge clock); #2;
        rst_n = 1'b1;

        applyStimulus(11'd0,    16'h0000);
        applyStimulus(11'd1,    16'h0002);
        applyStimulus(11'd100,  16'h0428);
        applyStimulus(11'd2047, 16'hE250);
        applyStimulus(11'd1234, 16'h9042);

        // Backpressure: hold the result, keep in_valid high with a different word.
        waitAllIdle();
        @(posedge clock); #2;
        out_ready = 1'b0;
        datain    = 11'd100;
        in_valid  = 1'b1;
        repeat (18) @(posedge clock);
        #2;
        datain = 11'd2047;
        repeat (10) begin
            @(posedge clock); #1;
            checkOutput("bp codeout", codeout[0], 16'h0428);
            checkOutput("bp in_ready", in_ready[0], 1'b0);
            checkOutput("bp out_valid", out_valid[0], 1'b1);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clock); #1;
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("s%0d in_ready after pulse", d), in_ready[d], 1'b1);
            checkOutput($sformatf("s%0d codeout after pulse", d), codeout[d], 16'h0428);
        end

        // Reset in the middle of RUN discards the word at once.
        waitAllIdle();
        @(posedge clock); #2;
        datain   = 11'd2047;
        in_valid = 1'b1;
        @(posedge clock); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            checkOutput($sformatf("s%0d midrun reset out_valid", d), out_valid[d], 1'b0);
            checkOutput($sformatf("s%0d midrun reset in_ready", d), in_ready[d], 1'b1);
            checkOutput($sformatf("s%0d midrun reset codeout", d), codeout[d], 16'h0000);
        end
        @(posedge clock); #2;
        rst_n = 1'b1;

        applyStimulus(11'd2047, 16'hE250);
        applyStimulus(11'd1,    16'h0002);

        waitAllIdle();
        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
